// File: rtl/ysyx_24100027_lsu_pkg.sv
// Shared constants, state encoding and request payload for the load/store unit.
package ysyx_24100027_lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MASKW = 4;

  // RV32I memory funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [MASKW-1:0] MASK_B = 4'b0001;
  localparam logic [MASKW-1:0] MASK_H = 4'b0011;
  localparam logic [MASKW-1:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic             wen;
    logic [XLEN-1:0]  wdata;
    logic [MASKW-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_24100027_lsu_if.sv
// Upstream, memory and writeback handshakes of the load/store unit.
interface ysyx_24100027_lsu_if;
  import ysyx_24100027_lsu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_addr;
  logic [XLEN-1:0]  in_wdata;
  logic [2:0]       in_func3;
  logic             in_ren;
  logic             in_wen;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [XLEN-1:0]  mem_addr;
  logic             mem_wen;
  logic [XLEN-1:0]  mem_wdata;
  logic [MASKW-1:0] mem_wmask;
  logic             mem_resp_valid;
  logic [XLEN-1:0]  mem_rdata;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rdata;
  logic             out_fault;

  // Environment side: drives ops, serves memory, consumes results
  modport master (
    output in_valid, in_addr, in_wdata, in_func3, in_ren, in_wen,
    output mem_req_ready, mem_resp_valid, mem_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  out_valid, out_rdata, out_fault
  );

  // Load/store unit side
  modport slave (
    input  in_valid, in_addr, in_wdata, in_func3, in_ren, in_wen,
    input  mem_req_ready, mem_resp_valid, mem_rdata, out_ready,
    output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output out_valid, out_rdata, out_fault
  );
endinterface

// File: rtl/ysyx_24100027_lsu_align.sv
// Byte-lane logic: load extraction/extension, store lane replication, mask and fault.
module ysyx_24100027_lsu_align
  import ysyx_24100027_lsu_pkg::*;
(
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       func3,
  input  logic             ren,
  input  logic             wen,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  load_data_c,
  output logic [XLEN-1:0]  store_data_c,
  output logic [MASKW-1:0] store_mask_c,
  output logic             fault_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign byte_c = rdata[{addr_lo, 3'b000} +: 8];
  assign half_c = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Misalignment, illegal funct3, loads-only widths used by a store, ambiguous op
  always_comb begin
    fault_c = 1'b0;
    case (func3)
      LB, LBU: fault_c = 1'b0;
      LH, LHU: fault_c = addr_lo[0];
      LW:      fault_c = (addr_lo != 2'b00);
      default: fault_c = 1'b1;
    endcase
    if (wen && func3[2]) fault_c = 1'b1;
    if (ren == wen)      fault_c = 1'b1;
  end

  // Sign/zero extension of the addressed lane
  always_comb begin
    load_data_c = rdata;
    case (func3)
      LB:      load_data_c = {{24{byte_c[7]}}, byte_c};
      LH:      load_data_c = {{16{half_c[15]}}, half_c};
      LBU:     load_data_c = {24'h0, byte_c};
      LHU:     load_data_c = {16'h0, half_c};
      default: load_data_c = rdata;
    endcase
  end

  // Store lanes replicated across the word, mask selects the addressed bytes
  always_comb begin
    store_data_c = wdata;
    store_mask_c = '0;
    if (wen) begin
      case (func3)
        SB: begin
          store_data_c = {4{wdata[7:0]}};
          store_mask_c = MASK_B << addr_lo;
        end
        SH: begin
          store_data_c = {2{wdata[15:0]}};
          store_mask_c = MASK_H << {addr_lo[1], 1'b0};
        end
        SW: begin
          store_data_c = wdata;
          store_mask_c = MASK_W;
        end
        default: store_mask_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_24100027_lsu.sv
// Multi-cycle load/store unit: one aligned word request per op, no pipelining.
module ysyx_24100027_lsu
  import ysyx_24100027_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ysyx_24100027_lsu_if.slave bus
);

  state_t           state;
  state_t           state_n;
  logic [1:0]       addr_lo_q;
  logic [2:0]       func3_q;
  logic             ren_q;
  mem_req_t         req_q;
  logic             in_ready_q;
  logic             mem_req_valid_q;
  logic             out_valid_q;
  logic             out_fault_q;
  logic [XLEN-1:0]  out_rdata_q;

  logic             accept_c;
  logic [1:0]       al_addr_c;
  logic [2:0]       al_func3_c;
  logic [XLEN-1:0]  load_data_c;
  logic [XLEN-1:0]  store_data_c;
  logic [MASKW-1:0] store_mask_c;
  logic             fault_c;

  // While idle the lane logic decodes the incoming op; afterwards the latched one
  assign accept_c   = (state == ST_IDLE) && bus.in_valid;
  assign al_addr_c  = (state == ST_IDLE) ? bus.in_addr[1:0] : addr_lo_q;
  assign al_func3_c = (state == ST_IDLE) ? bus.in_func3 : func3_q;

  ysyx_24100027_lsu_align u_align (
    .addr_lo      (al_addr_c),
    .func3        (al_func3_c),
    .ren          (bus.in_ren),
    .wen          (bus.in_wen),
    .wdata        (bus.in_wdata),
    .rdata        (bus.mem_rdata),
    .load_data_c  (load_data_c),
    .store_data_c (store_data_c),
    .store_mask_c (store_mask_c),
    .fault_c      (fault_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; faults skip the memory phase entirely
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept_c)           state_n = fault_c ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus.mem_req_ready)  state_n = ST_WAIT;
      ST_WAIT: if (bus.mem_resp_valid) state_n = ST_DONE;
      ST_DONE: if (bus.out_ready)      state_n = ST_IDLE;
      default:                         state_n = ST_IDLE;
    endcase
  end

  // Registered handshakes, latched op, request payload and result
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_fault_q     <= 1'b0;
      out_rdata_q     <= '0;
      addr_lo_q       <= '0;
      func3_q         <= '0;
      ren_q           <= 1'b0;
      req_q           <= '0;
    end else begin
      in_ready_q      <= (state_n == ST_IDLE);
      mem_req_valid_q <= (state_n == ST_REQ);
      out_valid_q     <= (state_n == ST_DONE);
      if (accept_c) begin
        addr_lo_q   <= bus.in_addr[1:0];
        func3_q     <= bus.in_func3;
        ren_q       <= bus.in_ren;
        out_rdata_q <= '0;
        out_fault_q <= fault_c;
        if (!fault_c) begin
          req_q.addr  <= {bus.in_addr[XLEN-1:2], 2'b00};
          req_q.wen   <= bus.in_wen;
          req_q.wdata <= store_data_c;
          req_q.wmask <= store_mask_c;
        end
      end
      if ((state == ST_WAIT) && bus.mem_resp_valid && ren_q) begin
        out_rdata_q <= load_data_c;
      end
      if ((state == ST_DONE) && bus.out_ready) begin
        out_rdata_q <= '0;
        out_fault_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = req_q.addr;
  assign bus.mem_wen       = req_q.wen;
  assign bus.mem_wdata     = req_q.wdata;
  assign bus.mem_wmask     = req_q.wmask;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_fault     = out_fault_q;

endmodule

// File: tb/tb_ysyx_24100027_lsu.sv
// Directed scoreboard bench for the load/store unit.
module tb_ysyx_24100027_lsu;
  import ysyx_24100027_lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_24100027_lsu_if bus ();

  ysyx_24100027_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_flags"}, 32'({bus.in_ready, bus.mem_req_valid, bus.mem_wen, bus.mem_wmask,
                              bus.out_valid, bus.out_fault}), 32'h100);
    chk({tag, "_addr"},  bus.mem_addr,  32'h0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_rdata"}, bus.out_rdata, 32'h0);
  endtask

  task automatic send(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                      input logic ren, input logic wen, input logic [31:0] e_rdata,
                      input logic e_fault);
    int g = 0;
    exp_t e;
    while (!bus.in_ready && g < 50) begin tick(); g++; end
    chk("send_in_ready", 32'(bus.in_ready), 32'h1);
    bus.in_addr  = addr;
    bus.in_wdata = wdata;
    bus.in_func3 = f3;
    bus.in_ren   = ren;
    bus.in_wen   = wen;
    bus.in_valid = 1'b1;
    tick();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    e.rdata      = e_rdata;
    e.fault      = e_fault;
    sb_q.push_back(e);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] e_addr, input logic e_wen,
                         input logic [31:0] e_wdata, input logic [3:0] e_mask);
    chk({tag, "_valid"}, 32'(bus.mem_req_valid), 32'h1);
    chk({tag, "_addr"}, bus.mem_addr, e_addr);
    chk({tag, "_wen_mask"}, 32'({bus.mem_wen, bus.mem_wmask}), 32'({e_wen, e_mask}));
    if (e_wen) chk({tag, "_wdata"}, bus.mem_wdata, e_wdata);
  endtask

  task automatic serve(input logic [31:0] rdata, input int hold, input logic [31:0] e_addr,
                       input logic e_wen, input logic [31:0] e_wdata, input logic [3:0] e_mask);
    int g = 0;
    while (!bus.mem_req_valid && g < 50) begin tick(); g++; end
    for (int i = 0; i < hold; i++) begin
      chk_req("req_hold", e_addr, e_wen, e_wdata, e_mask);
      tick();
    end
    chk_req("req", e_addr, e_wen, e_wdata, e_mask);
    bus.mem_req_ready  = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = rdata;
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input int exp_lat);
    int   g = 0;
    exp_t e;
    while (!bus.out_valid && g < 50) begin tick(); g++; end
    chk("out_valid", 32'(bus.out_valid), 32'h1);
    if (exp_lat > 0) chk("latency", 32'(cyc - acc_cyc + 1), 32'(exp_lat));
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'h1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      for (int i = 0; i < hold; i++) begin
        chk("out_hold_valid", 32'(bus.out_valid), 32'h1);
        chk("out_hold_rdata", bus.out_rdata, e.rdata);
        chk("out_hold_fault", 32'(bus.out_fault), 32'(e.fault));
        chk("out_hold_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
      end
      chk("out_rdata", bus.out_rdata, e.rdata);
      chk("out_fault", 32'(bus.out_fault), 32'(e.fault));
      chk("done_in_ready", 32'(bus.in_ready), 32'h0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("post_in_ready", 32'(bus.in_ready), 32'h1);
      chk("post_out_valid", 32'(bus.out_valid), 32'h0);
    end
  endtask

  // Absolute time bound for the whole run
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_addr        = '0;
    bus.in_wdata       = '0;
    bus.in_func3       = '0;
    bus.in_ren         = 1'b0;
    bus.in_wen         = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    bus.out_ready      = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outs("reset");

    // lw, zero-wait memory, 3-cycle latency
    send(32'h8000_0004, 32'h0, LW, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    serve(32'hDEAD_BEEF, 0, 32'h8000_0004, 1'b0, 32'h0, 4'b0000);
    collect(0, 3);

    // byte/half extraction and extension
    send(32'h8000_0003, 32'h0, LB, 1'b1, 1'b0, 32'hFFFF_FF80, 1'b0);
    serve(32'h80FF_0000, 0, 32'h8000_0000, 1'b0, 32'h0, 4'b0000);
    collect(0, 3);
    send(32'h8000_0003, 32'h0, LBU, 1'b1, 1'b0, 32'h0000_0080, 1'b0);
    serve(32'h80FF_0000, 0, 32'h8000_0000, 1'b0, 32'h0, 4'b0000);
    collect(0, 3);
    send(32'h8000_0102, 32'h0, LH, 1'b1, 1'b0, 32'hFFFF_80FF, 1'b0);
    serve(32'h80FF_0000, 0, 32'h8000_0100, 1'b0, 32'h0, 4'b0000);
    collect(0, -1);
    send(32'h8000_0100, 32'h0, LHU, 1'b1, 1'b0, 32'h0000_8001, 1'b0);
    serve(32'h1234_8001, 0, 32'h8000_0100, 1'b0, 32'h0, 4'b0000);
    collect(0, -1);
    send(32'h8000_0101, 32'h0, LB, 1'b1, 1'b0, 32'h0000_007F, 1'b0);
    serve(32'h0000_7F00, 0, 32'h8000_0100, 1'b0, 32'h0, 4'b0000);
    collect(0, -1);

    // stores: lanes, masks, completion-only result
    send(32'h8000_0002, 32'h1234_ABCD, SH, 1'b0, 1'b1, 32'h0, 1'b0);
    serve(32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b1, 32'hABCD_ABCD, 4'b1100);
    collect(0, 3);
    send(32'h8000_0001, 32'h0000_0055, SB, 1'b0, 1'b1, 32'h0, 1'b0);
    serve(32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b1, 32'h5555_5555, 4'b0010);
    collect(0, -1);
    send(32'h8000_0008, 32'hCAFE_F00D, SW, 1'b0, 1'b1, 32'h0, 1'b0);
    serve(32'hFFFF_FFFF, 0, 32'h8000_0008, 1'b1, 32'hCAFE_F00D, 4'b1111);
    collect(0, -1);

    // faults: result after one cycle, never a memory request
    send(32'h8000_0001, 32'h0, LW, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("fault_lw_no_req", 32'(bus.mem_req_valid), 32'h0);
    collect(0, 1);
    send(32'h8000_0003, 32'h0, LH, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("fault_lh_no_req", 32'(bus.mem_req_valid), 32'h0);
    collect(0, 1);
    send(32'h8000_0002, 32'h0, 3'b011, 1'b1, 1'b0, 32'h0, 1'b1);
    collect(0, 1);
    send(32'h8000_0000, 32'h1, 3'b100, 1'b0, 1'b1, 32'h0, 1'b1);
    chk("fault_st_bu_no_req", 32'(bus.mem_req_valid), 32'h0);
    collect(0, 1);
    send(32'h8000_0000, 32'h0, LW, 1'b1, 1'b1, 32'h0, 1'b1);
    collect(0, 1);
    send(32'h8000_0000, 32'h0, LW, 1'b0, 1'b0, 32'h0, 1'b1);
    collect(0, 1);
    chk("fault_mem_idle", 32'(bus.mem_req_valid), 32'h0);

    // back-pressure on both handshakes
    send(32'h8000_0010, 32'h0, LW, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0);
    serve(32'h0BAD_F00D, 5, 32'h8000_0010, 1'b0, 32'h0, 4'b0000);
    collect(3, -1);

    // reset while waiting for the response, then a stray response
    send(32'h8000_0020, 32'h0, LW, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_req("rst_req", 32'h8000_0020, 1'b0, 32'h0, 4'b0000);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk_reset_outs("rst_wait");
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1111_1111;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk_reset_outs("stray_resp");
    tick();
    chk_reset_outs("stray_settle");
    send(32'h8000_0024, 32'h0, LW, 1'b1, 1'b0, 32'h600D_600D, 1'b0);
    serve(32'h600D_600D, 0, 32'h8000_0024, 1'b0, 32'h0, 4'b0000);
    collect(0, 3);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100027_lsu.md
# ysyx_24100027_lsu

Multi-cycle load/store unit placed directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, along with the store operand and the RV32I memory funct3. It issues one aligned word request on a valid/ready memory port, then waits for the response. For loads it extracts and extends the addressed byte, half or word and returns it to writeback on a second valid/ready handshake; stores return a completion-only handshake.

## Interface
Parameters:
- None; all widths fixed at RV32 (32-bit address and data, 4-bit byte mask).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream holds a memory op
- in_ready  out  1  unit can accept an op
- in_addr  in  32  effective address (ALU result)
- in_wdata  in  32  store operand (rs2)
- in_func3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- in_ren  in  1  load
- in_wen  in  1  store
- mem_req_valid  out  1  request pending
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  {in_addr[31:2], 2'b00}
- mem_wen  out  1  request is a write
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte enables; 4'b0000 on reads
- mem_resp_valid  in  1  read data / write ack, one-cycle pulse
- mem_rdata  in  32  read word
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_rdata  out  32  extended load data; 0 for stores and faults
- out_fault  out  1  misaligned address or illegal op

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: in_ready=1. On in_valid, latch all in_* inputs.
    - Legal op -> REQ.
    - Fault -> DONE with out_fault=1; no memory request is issued.
  - REQ: mem_req_valid=1; mem_* outputs are stable from latched values. On mem_req_ready -> WAIT.
  - WAIT: on mem_resp_valid, latch the extended data (loads) -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE.
- Fault conditions:
  - h/hu with addr[0]=1.
  - w with addr[1:0]!=0.
  - funct3 not in {000,001,010,100,101}.
  - Store with funct3 100/101.
  - in_ren==in_wen (both set or both clear).
- Store lanes:
  - sb: mask 4'b0001<<addr[1:0]; data {4{wdata[7:0]}}.
  - sh: mask 4'b0011<<{addr[1],1'b0}; data {2{wdata[15:0]}}.
  - sw: mask 4'b1111; data wdata.
- Load extract:
  - byte = rdata[8*addr[1:0] +: 8].
  - half = rdata[16*addr[1] +: 16].
  - b/h sign-extend; bu/hu zero-extend; w passes through.
- No pipelining: exactly one op in flight.

## Timing
- Reset values: in_ready=1; all other outputs 0; state IDLE; latched registers 0.
- mem_req_valid, once asserted, stays high with stable payload until mem_req_ready is sampled high (no withdrawal).
- out_valid, out_rdata and out_fault stay stable until out_ready is sampled high.
- Accept in cycle 0:
  - mem_req_valid rises in cycle 1.
  - With zero-wait memory, req handshake in cycle 1 and response in cycle 2 give out_valid in cycle 3. Minimum legal latency is 3 cycles.
- Fault path: accept in cycle 0 -> out_valid in cycle 1.
- Response timing:
  - Memory must not return a response in the request-handshake cycle.
  - A mem_resp_valid seen outside WAIT is ignored.
- Back-to-back ops: when out_ready is high in DONE, in_ready rises the next cycle. There is no same-cycle turnaround.
- rst asserted in any state: next cycle is IDLE with reset output values. An in-flight memory transaction is abandoned, and memory is reset by the same rst.

## Structure
- Shared package holds:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encoding (2 bits).
  - MASK_B, MASK_H, MASK_W constants.
- Sub-module ysyx_24100027_lsu_align (combinational) takes addr[1:0], func3 and rdata/wdata and produces extended load data, store lanes, mask and the fault flag. The top level holds the FSM and registers.

## Test plan
- lw at 0x8000_0004, mem_rdata=0xDEAD_BEEF, zero-wait memory -> mem_addr=0x8000_0004, mask 0; out_valid in cycle 3; out_rdata=0xDEAD_BEEF.
- lb at 0x...03 and lbu at 0x...03, rdata=0x80FF_0000 -> lb: out_rdata=0xFFFF_FF80; lbu: out_rdata=0x0000_0080.
- sh at 0x...02, wdata=0x1234_ABCD -> mem_wmask=4'b1100, mem_wdata=0xABCD_ABCD, mem_wen=1; out_rdata=0, out_fault=0.
- lw at 0x...01 -> out_valid in cycle 1 with out_fault=1; mem_req_valid never rises.
- mem_req_ready held low 5 cycles, then out_ready held low 3 cycles -> mem payload stable throughout; out_valid held 3 cycles; in_ready stays 0 until the cycle after out_ready.
- rst pulsed in WAIT, then a stray mem_resp_valid arrives -> unit returns to IDLE with all outputs at reset values; the stray response is ignored; the next lw completes normally.
